pulse_num_multiplier: RTL and testbench
=======================================

# pulse_num_multiplier

Scales signed per-axis position deltas (position units) into signed stepper pulse counts by fixed per-axis factors. It widens from position width to pulse-count width and saturates at the output range. It sits between the motion planner (upstream master of a MotorsCtrl_IF) and the motors controller (downstream slave of a MotorsCtrl_IF). Command fields are registered once; handshake return signals pass straight through.

## Interface
- Clock and reset: one clock; reset is synchronous and active-high.
- IN_X_BITS, default 12 (POS_X_BITS): signed width of upstream pulse_num_x.
- IN_Y_BITS, default 12 (POS_Y_BITS): signed width of upstream pulse_num_y.
- OUT_X_BITS, default 16 (STEPPER_PULSE_NUM_X_BITS): signed width of downstream pulse_num_x.
- OUT_Y_BITS, default 16 (STEPPER_PULSE_NUM_Y_BITS): signed width of downstream pulse_num_y.
- MULT_X, default 8: positive integer pulses per X position unit.
- MULT_Y, default 8: positive integer pulses per Y position unit.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- intf_in  MotorsCtrl_IF.slave  IN_X/IN_Y widths  upstream command.
  - Fields: pulse_num_x, pulse_num_y, servo_pos, trigger (in); rdy, done (out).
- intf_out  MotorsCtrl_IF.master  OUT_X/OUT_Y widths  downstream command.
  - Same fields with directions reversed.
- MotorsCtrl_IF parameters: PULSE_NUM_X_BITS and PULSE_NUM_Y_BITS.
- servo_pos type: Servo_PKG servo position (SERVO_POS_UP / SERVO_POS_DOWN).

## Operation
- Every cycle: out.pulse_num_x <= sat_OUT_X_BITS(signed(in.pulse_num_x) * MULT_X); Y likewise with MULT_Y.
- Inputs are two's complement.
  - Sign-extend to at least IN+clog2(MULT)+1 bits before multiplying.
  - Products never wrap.
- Saturation: product > 2^(OUT-1)-1 → 2^(OUT-1)-1; product < -2^(OUT-1) → -2^(OUT-1); otherwise exact.
- out.servo_pos <= in.servo_pos and out.trigger <= in.trigger, registered in the same stage as the pulse counts.
  - Trigger, servo position and scaled counts always arrive downstream in the same cycle.
- in.rdy = out.rdy and in.done = out.done, purely combinational; no extra gating.
- No state machine; the block is a single register stage plus combinational scale/saturate logic.
- Reset (synchronous, overrides the data path):
  - pulse_num_x/y = 0, trigger = 0, servo_pos = SERVO_POS_UP.
  - Reset mid-command drops any trigger in flight.

## Timing
- Latency for pulse_num, servo_pos and trigger: exactly 1 clk.
  - Input sampled at edge N appears at output after edge N.
- A 1-cycle trigger pulse in produces a 1-cycle trigger pulse out, delayed by one cycle.
- Back-to-back triggers are preserved cycle for cycle.
- rdy/done: 0-cycle combinational path.
- Upstream must hold its command for the cycle it asserts trigger (existing MotorsCtrl_IF rule).
- The cycle after reset deasserts, outputs reflect inputs sampled on that edge.

## Structure
- Shared package Motors_PKG holds:
  - POS_X/Y_BITS and STEPPER_PULSE_NUM_X/Y_BITS defaults.
  - Default MULT_X/MULT_Y constants.
- Servo position type stays in Servo_PKG.
- One sub-module, pulse_num_scaler (parameters IN_BITS, OUT_BITS, MULT; combinational sign-extend, multiply, saturate).
  - Instantiated once per axis.
  - The top holds the register stage and the interface wiring.

## Test plan
- Defaults, in (3,2), no trigger; after 2 clk → out (24,16).
- In (4,-5) → (32,-40); in (-1,0) → (-8,0); servo_pos and trigger passthrough values match the inputs.
- Saturation with MULT_X=32: in x=2047 → 32767; x=-2048 → -32768; x=1023 → 32736 (exact).
- Trigger pulse of 1 cycle with servo_pos=DOWN and (5,-7): one cycle later trigger=1 for exactly 1 cycle with DOWN and (40,-56).
- Drive out.rdy/out.done patterns 0/1: in.rdy/in.done follow in the same cycle.
- Assert reset while a trigger is in flight: next edge out = (0,0), trigger 0, SERVO_POS_UP; the trigger is not forwarded.

Source files
------------

// File: rtl/Motors_PKG.sv
// Shared motor-path widths and default position-to-pulse scale factors.
package Motors_PKG;

   localparam int POS_X_BITS               = 12;
   localparam int POS_Y_BITS               = 12;
   localparam int STEPPER_PULSE_NUM_X_BITS = 16;
   localparam int STEPPER_PULSE_NUM_Y_BITS = 16;
   localparam int MULT_X_DEFAULT           = 8;
   localparam int MULT_Y_DEFAULT           = 8;

   // Width that holds in_bits * mult for any signed input without wrapping.
   function automatic int scaled_bits(input int in_bits, input int mult);
      return in_bits + $clog2(mult) + 1;
   endfunction

endpackage

// File: rtl/Servo_PKG.sv
// Servo position encoding shared by the motion planner, the motors controller and
// everything in between.
package Servo_PKG;

   typedef enum logic {
      SERVO_POS_UP   = 1'b0,
      SERVO_POS_DOWN = 1'b1
   } servo_pos_t;

endpackage

// File: rtl/MotorsCtrl_IF.sv
// Command/handshake bundle between the motion planner and the motors controller.
interface MotorsCtrl_IF #(
   parameter int PULSE_NUM_X_BITS = 16,
   parameter int PULSE_NUM_Y_BITS = 16
);
   import Servo_PKG::*;

   logic signed [PULSE_NUM_X_BITS-1:0] pulse_num_x;
   logic signed [PULSE_NUM_Y_BITS-1:0] pulse_num_y;
   servo_pos_t                         servo_pos;
   logic                               trigger;
   logic                               rdy;
   logic                               done;

   modport master (output pulse_num_x, pulse_num_y, servo_pos, trigger,
                   input  rdy, done);
   modport slave  (input  pulse_num_x, pulse_num_y, servo_pos, trigger,
                   output rdy, done);

endinterface

// File: rtl/pulse_num_scaler.sv
// Combinational signed scale-by-constant with saturation to the output width.
module pulse_num_scaler
   import Motors_PKG::*;
#(
   parameter int IN_BITS  = POS_X_BITS,
   parameter int OUT_BITS = STEPPER_PULSE_NUM_X_BITS,
   parameter int MULT     = MULT_X_DEFAULT
) (
   input  logic signed [IN_BITS-1:0]  in_i,
   output logic signed [OUT_BITS-1:0] out_o
);

   localparam int EXT_BITS = scaled_bits(IN_BITS, MULT);
   // One bit wider than both product and output so the limit compares stay signed-exact.
   localparam int W = ((EXT_BITS > OUT_BITS) ? EXT_BITS : OUT_BITS) + 1;

   localparam logic signed [W-1:0] MULT_S  = W'(MULT);
   localparam logic signed [W-1:0] OUT_MAX = {{(W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
   localparam logic signed [W-1:0] OUT_MIN = {{(W-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

   logic signed [W-1:0] in_ext;
   logic signed [W-1:0] product;

   assign in_ext  = {{(W-IN_BITS){in_i[IN_BITS-1]}}, in_i};
   assign product = in_ext * MULT_S;

   always_comb begin
      out_o = product[OUT_BITS-1:0];
      if (product > OUT_MAX) begin
         out_o = OUT_MAX[OUT_BITS-1:0];
      end else if (product < OUT_MIN) begin
         out_o = OUT_MIN[OUT_BITS-1:0];
      end
   end

endmodule

// File: rtl/pulse_num_multiplier.sv
// Converts planner position deltas into saturated stepper pulse counts, one register
// stage for the command fields, combinational pass-through for the handshake returns.
module pulse_num_multiplier
   import Motors_PKG::*;
   import Servo_PKG::*;
#(
   parameter int IN_X_BITS  = POS_X_BITS,
   parameter int IN_Y_BITS  = POS_Y_BITS,
   parameter int OUT_X_BITS = STEPPER_PULSE_NUM_X_BITS,
   parameter int OUT_Y_BITS = STEPPER_PULSE_NUM_Y_BITS,
   parameter int MULT_X     = MULT_X_DEFAULT,
   parameter int MULT_Y     = MULT_Y_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   MotorsCtrl_IF.slave  intf_in,
   MotorsCtrl_IF.master intf_out
);

   logic signed [OUT_X_BITS-1:0] pulse_x_d, pulse_x_q;
   logic signed [OUT_Y_BITS-1:0] pulse_y_d, pulse_y_q;
   servo_pos_t                   servo_q;
   logic                         trigger_q;

   pulse_num_scaler #(.IN_BITS(IN_X_BITS), .OUT_BITS(OUT_X_BITS), .MULT(MULT_X)) u_scale_x (
      .in_i  (intf_in.pulse_num_x),
      .out_o (pulse_x_d)
   );

   pulse_num_scaler #(.IN_BITS(IN_Y_BITS), .OUT_BITS(OUT_Y_BITS), .MULT(MULT_Y)) u_scale_y (
      .in_i  (intf_in.pulse_num_y),
      .out_o (pulse_y_d)
   );

   // Counts, servo position and trigger share one stage so they stay cycle-aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         pulse_x_q <= '0;
         pulse_y_q <= '0;
         servo_q   <= SERVO_POS_UP;
         trigger_q <= 1'b0;
      end else begin
         pulse_x_q <= pulse_x_d;
         pulse_y_q <= pulse_y_d;
         servo_q   <= intf_in.servo_pos;
         trigger_q <= intf_in.trigger;
      end
   end

   assign intf_out.pulse_num_x = pulse_x_q;
   assign intf_out.pulse_num_y = pulse_y_q;
   assign intf_out.servo_pos   = servo_q;
   assign intf_out.trigger     = trigger_q;

   assign intf_in.rdy  = intf_out.rdy;
   assign intf_in.done = intf_out.done;

endmodule

// File: tb/tb_pulse_num_multiplier.sv
// Bench for pulse_num_multiplier: default-scale instance plus a MULT_X=32 instance
// to reach output saturation, vector table, corner sequences and random traffic.
module tb_pulse_num_multiplier;
   import Motors_PKG::*;
   import Servo_PKG::*;

   localparam int IN_B  = POS_X_BITS;
   localparam int OUT_B = STEPPER_PULSE_NUM_X_BITS;
   localparam int M1X   = 8;
   localparam int M2X   = 32;
   localparam int MY    = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   MotorsCtrl_IF #(.PULSE_NUM_X_BITS(IN_B),  .PULSE_NUM_Y_BITS(IN_B))  in_if ();
   MotorsCtrl_IF #(.PULSE_NUM_X_BITS(OUT_B), .PULSE_NUM_Y_BITS(OUT_B)) out_if ();
   MotorsCtrl_IF #(.PULSE_NUM_X_BITS(IN_B),  .PULSE_NUM_Y_BITS(IN_B))  in2_if ();
   MotorsCtrl_IF #(.PULSE_NUM_X_BITS(OUT_B), .PULSE_NUM_Y_BITS(OUT_B)) out2_if ();

   assign in2_if.pulse_num_x = in_if.pulse_num_x;
   assign in2_if.pulse_num_y = in_if.pulse_num_y;
   assign in2_if.servo_pos   = in_if.servo_pos;
   assign in2_if.trigger     = in_if.trigger;
   assign out2_if.rdy        = out_if.rdy;
   assign out2_if.done       = out_if.done;

   pulse_num_multiplier dut (
      .clk      (clk),
      .reset    (reset),
      .intf_in  (in_if.slave),
      .intf_out (out_if.master)
   );

   pulse_num_multiplier #(.MULT_X(M2X)) dut_sat (
      .clk      (clk),
      .reset    (reset),
      .intf_in  (in2_if.slave),
      .intf_out (out2_if.master)
   );

   function automatic longint sat(input longint v, input int bits);
      longint hi = (longint'(1) <<< (bits - 1)) - 1;
      longint lo = -(longint'(1) <<< (bits - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input int x, input int y, input servo_pos_t s, input logic t);
      in_if.pulse_num_x = IN_B'(x);
      in_if.pulse_num_y = IN_B'(y);
      in_if.servo_pos   = s;
      in_if.trigger     = t;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full expected state of both instances after a registered transfer.
   task automatic chk_out(input string tag, input int x, input int y, input servo_pos_t s,
                          input logic t, input logic in_reset);
      longint ex  = in_reset ? 0 : sat(longint'(x) * M1X, OUT_B);
      longint ex2 = in_reset ? 0 : sat(longint'(x) * M2X, OUT_B);
      longint ey  = in_reset ? 0 : sat(longint'(y) * MY, OUT_B);
      servo_pos_t es = in_reset ? SERVO_POS_UP : s;
      logic       et = in_reset ? 1'b0 : t;
      chk({tag, " x"},      longint'(out_if.pulse_num_x), ex);
      chk({tag, " y"},      longint'(out_if.pulse_num_y), ey);
      chk({tag, " servo"},  longint'(out_if.servo_pos), longint'(es));
      chk({tag, " trig"},   longint'(out_if.trigger), longint'(et));
      chk({tag, " x32"},    longint'(out2_if.pulse_num_x), ex2);
      chk({tag, " y32"},    longint'(out2_if.pulse_num_y), ey);
      $display("%s in=(%0d,%0d) s=%0d t=%0d -> out=(%0d,%0d) x32=%0d s=%0d t=%0d", tag, x, y,
               s, t, out_if.pulse_num_x, out_if.pulse_num_y, out2_if.pulse_num_x,
               out_if.servo_pos, out_if.trigger);
   endtask

   typedef struct {
      int         x;
      int         y;
      servo_pos_t s;
      logic       t;
      int         ex;
      int         ey;
      int         ex32;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{3,     2,    SERVO_POS_UP,   1'b0, 24,     16,    96};
      vecs[1] = '{4,    -5,    SERVO_POS_DOWN, 1'b0, 32,    -40,    128};
      vecs[2] = '{-1,    0,    SERVO_POS_UP,   1'b1, -8,     0,    -32};
      vecs[3] = '{2047,  2047, SERVO_POS_DOWN, 1'b0, 16376,  16376, 32767};
      vecs[4] = '{-2048, -2048, SERVO_POS_UP,  1'b1, -16384, -16384, -32768};
      vecs[5] = '{1023,  -1,   SERVO_POS_DOWN, 1'b1, 8184,  -8,     32736};
      vecs[6] = '{1024,  0,    SERVO_POS_UP,   1'b0, 8192,   0,     32767};
      vecs[7] = '{-1024, 1,    SERVO_POS_DOWN, 1'b0, -8192,  8,    -32768};

      out_if.rdy  = 1'b0;
      out_if.done = 1'b0;
      drive(3, 2, SERVO_POS_DOWN, 1'b1);

      // Reset state while inputs are non-zero
      step();
      step();
      chk_out("reset", 3, 2, SERVO_POS_DOWN, 1'b1, 1'b1);

      // First cycle out of reset reflects inputs on that edge
      reset = 1'b0;
      drive(3, 2, SERVO_POS_UP, 1'b0);
      step();
      step();
      chk("post-reset x", longint'(out_if.pulse_num_x), 24);
      chk("post-reset y", longint'(out_if.pulse_num_y), 16);

      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].t);
         step();
         chk($sformatf("vec%0d x", i),   longint'(out_if.pulse_num_x),  longint'(vecs[i].ex));
         chk($sformatf("vec%0d y", i),   longint'(out_if.pulse_num_y),  longint'(vecs[i].ey));
         chk($sformatf("vec%0d x32", i), longint'(out2_if.pulse_num_x), longint'(vecs[i].ex32));
         chk($sformatf("vec%0d s", i),   longint'(out_if.servo_pos),    longint'(vecs[i].s));
         chk($sformatf("vec%0d t", i),   longint'(out_if.trigger),      longint'(vecs[i].t));
         $display("vec%0d in=(%0d,%0d) -> (%0d,%0d) x32=%0d", i, vecs[i].x, vecs[i].y,
                  out_if.pulse_num_x, out_if.pulse_num_y, out2_if.pulse_num_x);
      end

      // Single trigger pulse: exactly one cycle late, exactly one cycle wide
      drive(0, 0, SERVO_POS_UP, 1'b0);
      step();
      drive(5, -7, SERVO_POS_DOWN, 1'b1);
      #1;
      chk("pulse early trig", longint'(out_if.trigger), 0);
      step();
      chk_out("pulse", 5, -7, SERVO_POS_DOWN, 1'b1, 1'b0);
      drive(5, -7, SERVO_POS_DOWN, 1'b0);
      step();
      chk_out("pulse+1", 5, -7, SERVO_POS_DOWN, 1'b0, 1'b0);

      // Back-to-back triggers preserved
      drive(1, 1, SERVO_POS_UP, 1'b1);
      step();
      chk("b2b t0", longint'(out_if.trigger), 1);
      drive(2, 2, SERVO_POS_UP, 1'b1);
      step();
      chk("b2b t1", longint'(out_if.trigger), 1);
      chk("b2b x1", longint'(out_if.pulse_num_x), 16);
      drive(2, 2, SERVO_POS_UP, 1'b0);
      step();
      chk("b2b t2", longint'(out_if.trigger), 0);

      // Handshake returns are combinational
      for (int i = 0; i < 4; i++) begin
         out_if.rdy  = i[0];
         out_if.done = i[1];
         #1;
         chk($sformatf("rdy%0d", i),  longint'(in_if.rdy),  longint'(i[0]));
         chk($sformatf("done%0d", i), longint'(in_if.done), longint'(i[1]));
         $display("handshake rdy=%0d done=%0d -> in rdy=%0d done=%0d", i[0], i[1],
                  in_if.rdy, in_if.done);
      end

      // Reset with a trigger in flight drops it
      drive(5, -7, SERVO_POS_DOWN, 1'b1);
      reset = 1'b1;
      step();
      chk_out("rst-flight", 5, -7, SERVO_POS_DOWN, 1'b1, 1'b1);
      reset = 1'b0;
      drive(5, -7, SERVO_POS_DOWN, 1'b0);
      step();
      chk_out("rst-after", 5, -7, SERVO_POS_DOWN, 1'b0, 1'b0);

      // Random traffic against the arithmetic model
      for (int i = 0; i < 200; i++) begin
         int         rx = int'($urandom_range(0, 4095)) - 2048;
         int         ry = int'($urandom_range(0, 4095)) - 2048;
         servo_pos_t rs = servo_pos_t'(1'($urandom_range(0, 1)));
         logic       rt = 1'($urandom_range(0, 1));
         drive(rx, ry, rs, rt);
         step();
         chk_out($sformatf("rand%0d", i), rx, ry, rs, rt, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
